// File: rtl/csdf_expand.sv
// Tagged-token expander: pops one {tag, data} token and replays it NUM_OP times
// into all PORTS FIFOs of flux `tag`, with per-flux state and fixed-priority emit.
module csdf_expand #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int NUM_OP     = 4,
  localparam int TAG_WIDTH = $clog2(FLUX),
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH,
  localparam int CNT_W     = $clog2(NUM_OP + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              read_port_dout,
  input  logic                          read_port_empty,
  output logic                          read_port_read,
  output logic [PORTS*DATA_WIDTH-1:0]   write_port_din,
  output logic [FLUX*PORTS-1:0]         write_port_write,
  input  logic [FLUX*PORTS-1:0]         write_port_full,
  output logic                          tag_err
);

  logic [FLUX-1:0]       busy_q, busy_d;
  logic [DATA_WIDTH-1:0] val_q [FLUX];
  logic [DATA_WIDTH-1:0] val_d [FLUX];
  logic [CNT_W-1:0]      cnt_q [FLUX];
  logic [CNT_W-1:0]      cnt_d [FLUX];

  logic [TAG_WIDTH-1:0]  head_tag;
  logic [DATA_WIDTH-1:0] head_data;
  logic [FLUX-1:0]       tag_match;
  logic [FLUX-1:0]       ready;
  logic [FLUX-1:0]       grant;
  logic                  accept_ok;
  logic                  discard;

  assign head_tag  = read_port_dout[WIDTH-1:DATA_WIDTH];
  assign head_data = read_port_dout[DATA_WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_flux
      localparam logic [TAG_WIDTH-1:0] FI = TAG_WIDTH'(gi);
      assign tag_match[gi] = (head_tag == FI);
      // A flux emits only when every one of its ports can take the word.
      assign ready[gi] = busy_q[gi] && !(|write_port_full[gi*PORTS +: PORTS]);
      assign write_port_write[gi*PORTS +: PORTS] = {PORTS{grant[gi]}};
    end
  endgenerate

  // Out-of-range tags match no flux and are dropped; rst gates the combinational strobes.
  assign accept_ok      = rst && !read_port_empty && |(tag_match & ~busy_q);
  assign discard        = rst && !read_port_empty && !(|tag_match);
  assign read_port_read = accept_ok || discard;
  assign tag_err        = discard;

  // Isolate the lowest set ready bit.
  assign grant = ready & (~ready + FLUX'(1));

  always_comb begin
    write_port_din = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (grant[f]) write_port_din = {PORTS{val_q[f]}};
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int f = 0; f < FLUX; f++) begin
      val_d[f] = val_q[f];
      cnt_d[f] = cnt_q[f];
      if (accept_ok && tag_match[f]) begin
        val_d[f]  = head_data;
        cnt_d[f]  = CNT_W'(NUM_OP);
        busy_d[f] = 1'b1;
      end else if (grant[f]) begin
        cnt_d[f]  = cnt_q[f] - CNT_W'(1);
        busy_d[f] = (cnt_q[f] != CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int f = 0; f < FLUX; f++) begin
        val_q[f] <= '0;
        cnt_q[f] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int f = 0; f < FLUX; f++) begin
        val_q[f] <= val_d[f];
        cnt_q[f] <= cnt_d[f];
      end
    end
  end

endmodule

// File: tb/tb_csdf_expand.sv
// Directed bench for csdf_expand: a FLUX=2 instance for replay/backpressure/
// arbitration/reset and a FLUX=3 instance for out-of-range tag discard.
module tb_csdf_expand;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // FLUX=2, PORTS=2, NUM_OP=4, DATA_WIDTH=8
  logic [8:0]  dout_a;
  logic        empty_a;
  logic        read_a;
  logic [15:0] din_a;
  logic [3:0]  write_a;
  logic [3:0]  full_a;
  logic        tag_err_a;

  // FLUX=3, PORTS=2, NUM_OP=4, DATA_WIDTH=8
  logic [9:0]  dout_b;
  logic        empty_b;
  logic        read_b;
  logic [15:0] din_b;
  logic [5:0]  write_b;
  logic [5:0]  full_b;
  logic        tag_err_b;

  csdf_expand #(.DATA_WIDTH(8), .FLUX(2), .PORTS(2), .NUM_OP(4)) dut_a (
    .clk(clk), .rst(rst),
    .read_port_dout(dout_a), .read_port_empty(empty_a), .read_port_read(read_a),
    .write_port_din(din_a), .write_port_write(write_a), .write_port_full(full_a),
    .tag_err(tag_err_a)
  );

  csdf_expand #(.DATA_WIDTH(8), .FLUX(3), .PORTS(2), .NUM_OP(4)) dut_b (
    .clk(clk), .rst(rst),
    .read_port_dout(dout_b), .read_port_empty(empty_b), .read_port_read(read_b),
    .write_port_din(din_b), .write_port_write(write_b), .write_port_full(full_b),
    .tag_err(tag_err_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] q[$];
  logic        rd_s, te_s;
  logic [3:0]  wr_s;
  logic [15:0] din_s;
  int          nwrites;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on DUT A: present FIFO head, sample mid-cycle, pop on the edge.
  task automatic step();
    empty_a = (q.size() == 0);
    dout_a  = empty_a ? 9'h000 : q[0];
    @(negedge clk);
    rd_s  = read_a;
    wr_s  = write_a;
    din_s = din_a;
    te_s  = tag_err_a;
    @(posedge clk);
    if (rd_s && q.size() != 0) void'(q.pop_front());
    #1;
  endtask

  initial begin
    empty_a = 1'b0; dout_a = {1'b1, 8'h5A}; full_a = '0;
    empty_b = 1'b1; dout_b = '0;            full_b = '0;

    // Reset: outputs held at zero even with a token at the head
    @(posedge clk); @(negedge clk);
    check("rst_read",    read_a,    1'b0);
    check("rst_write",   write_a,   4'h0);
    check("rst_din",     din_a,     16'h0);
    check("rst_tag_err", tag_err_a, 1'b0);
    empty_a = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: single token tag 1, no backpressure
    q.push_back({1'b1, 8'h5A});
    for (int c = 0; c < 7; c++) begin
      step();
      check($sformatf("t1_read_c%0d", c),  rd_s,  (c == 0));
      check($sformatf("t1_write_c%0d", c), wr_s,  (c >= 1 && c <= 4) ? 4'b1100 : 4'b0000);
      check($sformatf("t1_din_c%0d", c),   din_s, (c >= 1 && c <= 4) ? 16'h5A5A : 16'h0000);
    end

    // T2: port 2 full during cycles 2-3 stalls the whole flux
    q.push_back({1'b1, 8'h5A});
    nwrites = 0;
    for (int c = 0; c < 8; c++) begin
      full_a = (c == 2 || c == 3) ? 4'b0100 : 4'b0000;
      step();
      if (wr_s != 4'b0000) nwrites++;
      check($sformatf("t2_write_c%0d", c), wr_s,
            (c == 1 || (c >= 4 && c <= 6)) ? 4'b1100 : 4'b0000);
    end
    full_a = '0;
    check("t2_nwrites", nwrites, 4);

    // T3: two fluxes back-to-back, flux 0 has priority
    q.push_back({1'b0, 8'h11});
    q.push_back({1'b1, 8'h22});
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("t3_read_c%0d", c), rd_s, (c <= 1));
      if (c >= 1 && c <= 4) begin
        check($sformatf("t3_write_c%0d", c), wr_s,  4'b0011);
        check($sformatf("t3_din_c%0d", c),   din_s, 16'h1111);
      end else if (c >= 5 && c <= 8) begin
        check($sformatf("t3_write_c%0d", c), wr_s,  4'b1100);
        check($sformatf("t3_din_c%0d", c),   din_s, 16'h2222);
      end else begin
        check($sformatf("t3_write_c%0d", c), wr_s,  4'b0000);
      end
    end

    // T4: same-tag tokens; the second waits for the first to finish
    q.push_back({1'b1, 8'hA0});
    q.push_back({1'b1, 8'hA1});
    for (int c = 0; c < 11; c++) begin
      step();
      check($sformatf("t4_read_c%0d", c), rd_s, (c == 0 || c == 5));
      check($sformatf("t4_write_c%0d", c), wr_s,
            ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 4'b1100 : 4'b0000);
      check($sformatf("t4_din_c%0d", c), din_s,
            (c >= 1 && c <= 4) ? 16'hA0A0 : (c >= 6 && c <= 9) ? 16'hA1A1 : 16'h0000);
      check($sformatf("t4_tag_err_c%0d", c), te_s, 1'b0);
    end

    // T5: FLUX=3 instance, tag 3 discarded, following token handled normally
    empty_b = 1'b0; dout_b = {2'd3, 8'h33};
    @(negedge clk);
    check("t5_bad_read",    read_b,    1'b1);
    check("t5_bad_tag_err", tag_err_b, 1'b1);
    check("t5_bad_write",   write_b,   6'h00);
    @(posedge clk); #1;
    dout_b = {2'd2, 8'h44};
    @(negedge clk);
    check("t5_ok_read",    read_b,    1'b1);
    check("t5_ok_tag_err", tag_err_b, 1'b0);
    check("t5_ok_write",   write_b,   6'h00);
    @(posedge clk); #1;
    empty_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t5_write_c%0d", c), write_b, (c <= 3) ? 6'b110000 : 6'b000000);
      check($sformatf("t5_din_c%0d", c),   din_b,   (c <= 3) ? 16'h4444 : 16'h0000);
      @(posedge clk); #1;
    end

    // T6: reset asserted mid-token clears outputs immediately, nothing resumes
    q.push_back({1'b0, 8'h77});
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t6_write_c%0d", c), wr_s, (c >= 1) ? 4'b0011 : 4'b0000);
    end
    empty_a = 1'b1;
    #2;
    check("t6_pre_rst_write", write_a, 4'b0011);
    rst = 1'b0;
    #1;
    check("t6_rst_write", write_a, 4'h0);
    check("t6_rst_din",   din_a,   16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("t6_post_write_c%0d", c), wr_s, 4'b0000);
      check($sformatf("t6_post_busy_c%0d", c), dut_a.busy_q, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
